mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-ported memory.
// Round-robin priority, one transaction in flight, fixed access latency,
// one-cycle response pulse with no backpressure.
module mem_arbiter #(
  parameter int LATENCY = 1  // cycles from accept to memory access, 1..15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // fetch port
  input  logic        ifu_req_valid_i,
  output logic        ifu_req_ready_o,
  input  logic [31:0] ifu_addr_i,
  output logic        ifu_resp_valid_o,
  output logic [31:0] ifu_rdata_o,
  // load/store port
  input  logic        lsu_req_valid_i,
  output logic        lsu_req_ready_o,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        lsu_wen_i,
  input  logic [3:0]  lsu_mask_i,
  output logic        lsu_resp_valid_o,
  output logic [31:0] lsu_rdata_o,
  // memory side
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_wen_o,
  output logic        mem_ren_o,
  output logic [3:0]  mem_mask_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        last_lsu_q;   // 1: LSU was granted last, so IFU wins the next tie
  logic        owner_lsu_q;  // owner of the transaction in flight
  logic [31:0] addr_q, wdata_q;
  logic        wen_q;
  logic [3:0]  mask_q;
  logic [31:0] ifu_rdata_q, lsu_rdata_q;

  logic lsu_prio, ifu_acc, lsu_acc, access;

  // Grant logic: a port is blocked only by a valid competitor holding priority.
  // Ready is also held low while reset is asserted so nothing is accepted then.
  assign lsu_prio        = ~last_lsu_q;
  assign ifu_req_ready_o = (state_q == IDLE) && !rst_i && !(lsu_req_valid_i && lsu_prio);
  assign lsu_req_ready_o = (state_q == IDLE) && !rst_i && !(ifu_req_valid_i && !lsu_prio);
  assign ifu_acc         = ifu_req_valid_i && ifu_req_ready_o;
  assign lsu_acc         = lsu_req_valid_i && lsu_req_ready_o;

  // The access cycle is the single BUSY cycle with the counter at 1.
  assign access = (state_q == BUSY) && (cnt_q == 4'd1);

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_mask_o  = mask_q;
  assign mem_ren_o   = access && !wen_q;
  assign mem_wen_o   = access &&  wen_q;

  assign ifu_resp_valid_o = (state_q == RESP) && !owner_lsu_q;
  assign lsu_resp_valid_o = (state_q == RESP) &&  owner_lsu_q;
  assign ifu_rdata_o      = ifu_rdata_q;
  assign lsu_rdata_o      = lsu_rdata_q;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: IDLE -> BUSY on accept, BUSY -> RESP after the access, RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ifu_acc || lsu_acc) state_d = BUSY;
      BUSY:    if (access)             state_d = RESP;
      RESP:                            state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Request latch, latency counter, and response data capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      last_lsu_q  <= 1'b0;
      owner_lsu_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      mask_q      <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      if (lsu_acc) begin
        owner_lsu_q <= 1'b1;
        last_lsu_q  <= 1'b1;
        addr_q      <= lsu_addr_i;
        wdata_q     <= lsu_wdata_i;
        wen_q       <= lsu_wen_i;
        mask_q      <= lsu_mask_i;
        cnt_q       <= 4'(LATENCY);
      end else if (ifu_acc) begin
        owner_lsu_q <= 1'b0;
        last_lsu_q  <= 1'b0;
        addr_q      <= ifu_addr_i;
        wdata_q     <= '0;
        wen_q       <= 1'b0;
        mask_q      <= 4'b1111;
        cnt_q       <= 4'(LATENCY);
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // Reads capture memory data for the owner; a store ack reports zero.
      if (access) begin
        if (wen_q)            lsu_rdata_q <= '0;
        else if (owner_lsu_q) lsu_rdata_q <= mem_rdata_i;
        else                  ifu_rdata_q <= mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: two instances (LATENCY 1 and 4), drivers
// push expected memory accesses and responses, a negedge monitor checks them.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int lat [2] = '{1, 4};

  logic        ifu_v   [2], ifu_rdy [2], ifu_rv [2];
  logic [31:0] ifu_a   [2], ifu_rd  [2];
  logic        lsu_v   [2], lsu_rdy [2], lsu_rv [2], lsu_we [2];
  logic [31:0] lsu_a   [2], lsu_wd  [2], lsu_rd [2];
  logic [3:0]  lsu_m   [2], m_mask  [2];
  logic [31:0] m_addr  [2], m_wdata [2], m_rdata [2];
  logic        m_wen   [2], m_ren   [2];

  // Memory model: a known word at the boot address, a simple hash elsewhere.
  // Data outside a read cycle is garbage so mistimed captures are visible.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h1234_5678);
  endfunction
  assign m_rdata[0] = m_ren[0] ? mem_f(m_addr[0]) : 32'hDEAD_BEEF;
  assign m_rdata[1] = m_ren[1] ? mem_f(m_addr[1]) : 32'hDEAD_BEEF;

  mem_arbiter #(.LATENCY(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .ifu_req_valid_i(ifu_v[0]), .ifu_req_ready_o(ifu_rdy[0]), .ifu_addr_i(ifu_a[0]),
    .ifu_resp_valid_o(ifu_rv[0]), .ifu_rdata_o(ifu_rd[0]),
    .lsu_req_valid_i(lsu_v[0]), .lsu_req_ready_o(lsu_rdy[0]), .lsu_addr_i(lsu_a[0]),
    .lsu_wdata_i(lsu_wd[0]), .lsu_wen_i(lsu_we[0]), .lsu_mask_i(lsu_m[0]),
    .lsu_resp_valid_o(lsu_rv[0]), .lsu_rdata_o(lsu_rd[0]),
    .mem_addr_o(m_addr[0]), .mem_wdata_o(m_wdata[0]), .mem_wen_o(m_wen[0]),
    .mem_ren_o(m_ren[0]), .mem_mask_o(m_mask[0]), .mem_rdata_i(m_rdata[0]));

  mem_arbiter #(.LATENCY(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .ifu_req_valid_i(ifu_v[1]), .ifu_req_ready_o(ifu_rdy[1]), .ifu_addr_i(ifu_a[1]),
    .ifu_resp_valid_o(ifu_rv[1]), .ifu_rdata_o(ifu_rd[1]),
    .lsu_req_valid_i(lsu_v[1]), .lsu_req_ready_o(lsu_rdy[1]), .lsu_addr_i(lsu_a[1]),
    .lsu_wdata_i(lsu_wd[1]), .lsu_wen_i(lsu_we[1]), .lsu_mask_i(lsu_m[1]),
    .lsu_resp_valid_o(lsu_rv[1]), .lsu_rdata_o(lsu_rd[1]),
    .mem_addr_o(m_addr[1]), .mem_wdata_o(m_wdata[1]), .mem_wen_o(m_wen[1]),
    .mem_ren_o(m_ren[1]), .mem_mask_o(m_mask[1]), .mem_rdata_i(m_rdata[1]));

  typedef struct {int inst; int cyc; logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask;} mexp_t;
  typedef struct {int inst; int port; int cyc; logic [31:0] data;} rexp_t;
  mexp_t mq[$];
  rexp_t rq[$];
  int qlo [2] = '{1, 1};
  int qhi [2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every memory strobe and response pulse must match the oldest
  // pending expectation for that instance/port, in cycle and data.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_ren[k] && m_wen[k]) chk("ren_wen_exclusive", 32'd1, 32'd0);
      if (m_ren[k] || m_wen[k]) begin
        int idx = -1;
        for (int i = 0; i < mq.size(); i++) if (mq[i].inst == k) begin idx = i; break; end
        if (idx < 0) chk("unexpected_mem_access", 32'(k), 32'hFFFF_FFFF);
        else begin
          chk("mem_cycle", 32'(cyc), 32'(mq[idx].cyc));
          chk("mem_wen",   {31'd0, m_wen[k]}, {31'd0, mq[idx].wr});
          chk("mem_addr",  m_addr[k], mq[idx].addr);
          chk("mem_mask",  {28'd0, m_mask[k]}, {28'd0, mq[idx].mask});
          if (mq[idx].wr) chk("mem_wdata", m_wdata[k], mq[idx].wdata);
          mq.delete(idx);
        end
      end
      for (int p = 0; p < 2; p++) begin
        logic pv;
        logic [31:0] pd;
        pv = (p == 0) ? ifu_rv[k] : lsu_rv[k];
        pd = (p == 0) ? ifu_rd[k] : lsu_rd[k];
        if (pv) begin
          int idx = -1;
          for (int i = 0; i < rq.size(); i++) if (rq[i].inst == k && rq[i].port == p) begin idx = i; break; end
          if (idx < 0) chk("unexpected_resp", 32'(k * 2 + p), 32'hFFFF_FFFF);
          else begin
            chk("resp_cycle", 32'(cyc), 32'(rq[idx].cyc));
            chk("resp_data",  pd, rq[idx].data);
            rq.delete(idx);
          end
        end
      end
      if (cyc >= qlo[k] && cyc <= qhi[k])
        chk("ready_low_in_flight", {30'd0, ifu_rdy[k], lsu_rdy[k]}, 32'd0);
    end
  end

  task automatic ifu_req(input int k, input logic [31:0] addr, input logic [31:0] exp);
    bit got = 0;
    ifu_a[k] = addr;
    ifu_v[k] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifu_rdy[k]) begin
        mq.push_back('{k, cyc + lat[k], 1'b0, addr, 32'd0, 4'hF});
        rq.push_back('{k, 0, cyc + lat[k] + 1, exp});
        qlo[k] = cyc + 1;
        qhi[k] = cyc + lat[k] + 1;
        got = 1;
        break;
      end
    end
    if (!got) chk("ifu_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    ifu_v[k] = 1'b0;
  endtask

  task automatic lsu_req(input int k, input logic [31:0] addr, input logic [31:0] wd,
                         input logic we, input logic [3:0] m, input logic [31:0] exp);
    bit got = 0;
    lsu_a[k] = addr; lsu_wd[k] = wd; lsu_we[k] = we; lsu_m[k] = m;
    lsu_v[k] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (lsu_rdy[k]) begin
        mq.push_back('{k, cyc + lat[k], we, addr, wd, m});
        rq.push_back('{k, 1, cyc + lat[k] + 1, exp});
        qlo[k] = cyc + 1;
        qhi[k] = cyc + lat[k] + 1;
        got = 1;
        break;
      end
    end
    if (!got) chk("lsu_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    lsu_v[k] = 1'b0;
  endtask

  // Both ports valid together on instance 0; checks who is granted first.
  task automatic tie(input logic lsu_first, input logic [31:0] ia, input logic [31:0] ie,
                     input logic [31:0] la, input logic [31:0] lwd, input logic lwe,
                     input logic [3:0] lm, input logic [31:0] le);
    fork
      ifu_req(0, ia, ie);
      lsu_req(0, la, lwd, lwe, lm, le);
      begin
        @(negedge clk);
        chk("tie_grant", {30'd0, lsu_rdy[0], ifu_rdy[0]}, lsu_first ? 32'd2 : 32'd1);
      end
    join
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (mq.size() + rq.size()) != 0; i++) @(posedge clk);
    #1;
    chk("pending_mem_expectations",  32'(mq.size()), 32'd0);
    chk("pending_resp_expectations", 32'(rq.size()), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      ifu_v[k] = 0; ifu_a[k] = 0; lsu_v[k] = 0; lsu_a[k] = 0;
      lsu_wd[k] = 0; lsu_we[k] = 0; lsu_m[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_addr",  m_addr[0], 32'd0);
    chk("rst_ifu_rdata", ifu_rd[0], 32'd0);
    chk("rst_lsu_rdata", lsu_rd[0], 32'd0);
    chk("rst_strobes",   {28'd0, m_ren[0], m_wen[0], ifu_rv[0], lsu_rv[0]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {30'd0, ifu_rdy[0], lsu_rdy[0]}, 32'd3);
    @(posedge clk); #1;

    // First tie after reset: LSU wins, IFU served after the LSU response.
    tie(1'b1, 32'h8000_0000, 32'h0000_0413, 32'h0000_0100, 32'd0, 1'b0, 4'hF, 32'h1234_5778);
    drain();
    // IFU was granted last, so LSU wins again; LSU side is a byte store.
    tie(1'b1, 32'h8000_0010, 32'h9234_5668, 32'h8000_0003, 32'h0000_00AB, 1'b1, 4'b1000, 32'd0);
    drain();
    // Lone fetch of the boot word.
    ifu_req(0, 32'h8000_0000, 32'h0000_0413);
    drain();
    // Lone load, so LSU is last; the following tie goes to IFU.
    lsu_req(0, 32'h8000_0000, 32'd0, 1'b0, 4'b0011, 32'h0000_0413);
    drain();
    tie(1'b0, 32'h0000_0100, 32'h1234_5778, 32'h8000_0010, 32'd0, 1'b0, 4'hF, 32'h9234_5668);
    drain();
    chk("ifu_rdata_hold", ifu_rd[0], 32'h1234_5778);

    // LATENCY=4 load.
    lsu_req(1, 32'h0000_0100, 32'd0, 1'b0, 4'hF, 32'h1234_5778);
    drain();

    // Reset while a LATENCY=4 load is in flight.
    lsu_req(1, 32'h8000_0010, 32'd0, 1'b0, 4'hF, 32'h9234_5668);
    @(posedge clk); #2;
    rst = 1'b1;
    mq.delete();
    rq.delete();
    qhi[0] = 0; qhi[1] = 0;
    #1;
    chk("midrst_strobes", {28'd0, m_ren[1], m_wen[1], ifu_rv[1], lsu_rv[1]}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    ifu_req(1, 32'h8000_0000, 32'h0000_0413);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
